// File: rtl/md_unit_if.sv
// Bundle between the E-stage pipeline and the multiply/divide unit:
// operation request, operands, D-stage hint, and HI/LO/busy/stall results.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_md;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    modport master (
        output start, md_op, a, b, d_md,
        input  busy, hi, lo, stall
    );

    modport slave (
        input  start, md_op, a, b, d_md,
        output busy, hi, lo, stall
    );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: holds HI/LO, computes the result at
// acceptance and commits it after a fixed busy latency.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave md
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_NOP7  = 3'd7
    } op_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   p_hi_q, p_hi_d;
    logic [31:0]   p_lo_q, p_lo_d;

    op_t           op;
    logic          is_mult;
    logic          is_div;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   dividend;
    logic [31:0]   divisor;
    logic          div_zero;
    logic [31:0]   uq;
    logic [31:0]   ur;
    logic [31:0]   sq;
    logic [31:0]   sr;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    assign op      = op_t'(md.md_op);
    assign is_mult = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);

    // Signed divide runs on magnitudes and restores signs afterwards, so
    // 0x80000000 / -1 wraps to 0x80000000 with no overflow special case.
    always_comb begin
        prod_u   = {32'b0, md.a} * {32'b0, md.b};
        prod_s   = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};

        a_mag    = md.a[31] ? (32'd0 - md.a) : md.a;
        b_mag    = md.b[31] ? (32'd0 - md.b) : md.b;
        div_zero = (md.b == '0);

        dividend = (op == OP_DIV) ? a_mag : md.a;
        divisor  = (op == OP_DIV) ? b_mag : md.b;
        if (div_zero) begin
            divisor = 32'd1;
        end

        uq = dividend / divisor;
        ur = dividend % divisor;
        sq = (md.a[31] ^ md.b[31]) ? (32'd0 - uq) : uq;
        sr = md.a[31] ? (32'd0 - ur) : ur;

        res_hi = hi_q;
        res_lo = lo_q;
        case (op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                if (!div_zero) begin
                    res_hi = sr;
                    res_lo = sq;
                end
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    res_hi = ur;
                    res_lo = uq;
                end
            end
            default: begin
                res_hi = hi_q;
                res_lo = lo_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;

        case (state_q)
            IDLE: begin
                if (md.start && (is_mult || is_div)) begin
                    p_hi_d  = res_hi;
                    p_lo_d  = res_lo;
                    count_d = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    state_d = RUN;
                end else if (!md.start) begin
                    if (op == OP_MTHI) begin
                        hi_d = md.a;
                    end
                    if (op == OP_MTLO) begin
                        lo_d = md.a;
                    end
                end
            end
            RUN: begin
                if (count_q == CW'(1)) begin
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
        end
    end

    assign md.busy  = (state_q == RUN);
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
    assign md.stall = md.d_md & (md.busy | md.start);
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of operations with hand-computed HI/LO
// and busy lengths, plus stall, restart-ignore and mid-run reset sequences.
module tb_md_unit;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    always #5 clk = ~clk;

    md_unit_if md ();

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (md)
    );

    typedef struct {
        logic        start;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one operation, scrambles operands every cycle while busy, then
    // checks busy length and committed HI/LO.
    task automatic run_vec(input string tag, input vec_t v);
        int unsigned n;
        @(negedge clk);
        md.start = v.start;
        md.md_op = v.op;
        md.a     = v.a;
        md.b     = v.b;
        @(posedge clk);
        #1;
        md.start = 1'b0;
        md.md_op = 3'd0;
        md.a     = $urandom;
        md.b     = $urandom;
        n = 0;
        while (md.busy && n < 100) begin
            n++;
            if (n == 1) begin
                check({tag, "_hidden_hi"}, md.hi, prev_hi);
                check({tag, "_hidden_lo"}, md.lo, prev_lo);
            end
            @(posedge clk);
            #1;
            md.a = $urandom;
            md.b = $urandom;
        end
        check({tag, "_busy_len"}, n, v.cycles);
        check({tag, "_hi"}, md.hi, v.hi);
        check({tag, "_lo"}, md.lo, v.lo);
        prev_hi = v.hi;
        prev_lo = v.lo;
    endtask

    initial begin
        int unsigned n;
        vec_t v;

        vecs[0]  = '{1'b1, 3'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{1'b1, 3'd2, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{1'b1, 3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{1'b1, 3'd4, 32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
        vecs[4]  = '{1'b0, 3'd5, 32'h12345678, 32'd0,        0,  32'h12345678, 32'h00000003};
        vecs[5]  = '{1'b0, 3'd6, 32'hCAFEF00D, 32'd0,        0,  32'h12345678, 32'hCAFEF00D};
        vecs[6]  = '{1'b1, 3'd3, 32'd5,        32'd0,        10, 32'h12345678, 32'hCAFEF00D};
        vecs[7]  = '{1'b1, 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[8]  = '{1'b1, 3'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{1'b1, 3'd1, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
        vecs[10] = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[11] = '{1'b1, 3'd5, 32'hDEADBEEF, 32'd0,        0,  32'hFFFFFFFE, 32'h00000001};
        vecs[12] = '{1'b1, 3'd4, 32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF};

        reset    = 1'b1;
        md.start = 1'b0;
        md.md_op = 3'd0;
        md.a     = '0;
        md.b     = '0;
        md.d_md  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        md.d_md = 1'b1;
        #1;
        check("reset_busy", 32'(md.busy), 32'd0);
        check("reset_hi", md.hi, 32'd0);
        check("reset_lo", md.lo, 32'd0);
        check("reset_stall", 32'(md.stall), 32'd0);
        md.d_md = 1'b0;
        reset   = 1'b0;
        prev_hi = '0;
        prev_lo = '0;

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Stall held through the whole multiply; a mid-run start is ignored.
        @(negedge clk);
        md.d_md  = 1'b1;
        md.start = 1'b1;
        md.md_op = 3'd1;
        md.a     = 32'd3;
        md.b     = 32'd4;
        #1;
        check("stall_start_cycle", 32'(md.stall), 32'd1);
        @(posedge clk);
        #1;
        md.start = 1'b0;
        md.md_op = 3'd0;
        n = 0;
        while (md.busy && n < 100) begin
            n++;
            check($sformatf("stall_busy%0d", n), 32'(md.stall), 32'd1);
            if (n == 2) begin
                md.start = 1'b1;
                md.md_op = 3'd3;
                md.a     = 32'd100;
                md.b     = 32'd7;
            end else begin
                md.start = 1'b0;
                md.md_op = 3'd0;
            end
            @(posedge clk);
            #1;
        end
        check("stall_busy_len", n, 32'd5);
        check("stall_after", 32'(md.stall), 32'd0);
        check("stall_hi", md.hi, 32'd0);
        check("stall_lo", md.lo, 32'd12);
        md.d_md = 1'b0;

        // Reset during the third busy cycle of a divide discards the result.
        @(negedge clk);
        md.start = 1'b1;
        md.md_op = 3'd3;
        md.a     = 32'd100;
        md.b     = 32'd7;
        @(posedge clk);
        #1;
        md.start = 1'b0;
        md.md_op = 3'd0;
        check("rst_run_busy", 32'(md.busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_run_busy_after", 32'(md.busy), 32'd0);
        check("rst_run_hi", md.hi, 32'd0);
        check("rst_run_lo", md.lo, 32'd0);
        prev_hi = '0;
        prev_lo = '0;
        v = '{1'b1, 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42};
        run_vec("post_reset_mult", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
